// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the cache fill / memory arbitration controller:
// FSM state encoding, block geometry and fill-owner encodings.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FILL  = 2'd2,
    ST_DONE  = 2'd3
  } fill_state_t;

  localparam int WORDS_PER_BLOCK   = 8;
  localparam int BLOCK_OFFSET_BITS = 4;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

endpackage

// File: rtl/cache_fill_ctrl_if.sv
// Bundle of cache-side miss/store lines and the unified-memory request/return bus.
// master = the fill controller, slave = caches plus memory.
interface cache_fill_ctrl_if #(
  parameter int ADDR_WIDTH = 16
);
  import mem_ctrl_pkg::*;

  logic                  i_miss;
  logic [ADDR_WIDTH-1:0] i_miss_addr;
  logic                  d_miss;
  logic [ADDR_WIDTH-1:0] d_miss_addr;
  logic                  d_wr_req;
  logic [ADDR_WIDTH-1:0] d_wr_addr;
  logic [15:0]           d_wr_data;
  logic                  d_wr_ack;

  logic                  mem_en;
  logic                  mem_wr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [15:0]           mem_wdata;
  logic [15:0]           mem_rdata;
  logic                  mem_rvalid;

  logic [ADDR_WIDTH-1:0] fill_addr;
  logic [15:0]           fill_data;
  logic                  i_data_wr;
  logic                  d_data_wr;
  logic                  i_write_tag;
  logic                  d_write_tag;
  logic                  busy;
  fill_state_t           dbg_state;

  // Handshakes: d_wr_req is held until the single-cycle d_wr_ack; misses are
  // level requests sampled only in IDLE; mem_en is a one-cycle request and
  // every read returns exactly one mem_rvalid pulse later (no back-pressure).
  modport master (
    input  i_miss, i_miss_addr, d_miss, d_miss_addr,
    input  d_wr_req, d_wr_addr, d_wr_data, mem_rdata, mem_rvalid,
    output d_wr_ack, mem_en, mem_wr, mem_addr, mem_wdata,
    output fill_addr, fill_data, i_data_wr, d_data_wr,
    output i_write_tag, d_write_tag, busy, dbg_state
  );

  modport slave (
    output i_miss, i_miss_addr, d_miss, d_miss_addr,
    output d_wr_req, d_wr_addr, d_wr_data, mem_rdata, mem_rvalid,
    input  d_wr_ack, mem_en, mem_wr, mem_addr, mem_wdata,
    input  fill_addr, fill_data, i_data_wr, d_data_wr,
    input  i_write_tag, d_write_tag, busy, dbg_state
  );

endinterface

// File: rtl/fill_counter.sv
// 3-bit word counter with synchronous clear and increment; wrap_o flags the
// increment that rolls 7 -> 0 (last word of the block).
module fill_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       inc_i,
  output logic [2:0] cnt_o,
  output logic       wrap_o
);

  logic [2:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = inc_i & ~clr_i & (cnt_q == 3'd7);

endmodule

// File: rtl/cache_fill_ctrl.sv
// Arbitrates D-cache stores, D-cache misses and I-cache misses onto one pipelined
// memory; a fill streams 8 words into the missing cache, then pulses its tag write.
module cache_fill_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int MEM_LAT    = 4
) (
  input  logic               clk,
  input  logic               rst,
  cache_fill_ctrl_if.master  bus
);

  if (MEM_LAT < 1 || WORDS_PER_BLOCK != 8) begin : g_param_check
    $error("cache_fill_ctrl: MEM_LAT must be >= 1 and blocks must hold 8 words");
  end

  localparam int HI_BITS = ADDR_WIDTH - BLOCK_OFFSET_BITS;

  fill_state_t           state_q, state_d;
  logic                  owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]           wr_data_q, wr_data_d;
  logic                  all_issued_q, all_issued_d;

  logic [2:0] req_cnt, ret_cnt;
  logic       req_wrap, ret_wrap;
  logic       cnt_clr, req_fire, ret_fire;

  assign cnt_clr  = (state_q == ST_IDLE);
  assign req_fire = (state_q == ST_FILL) & ~all_issued_q;
  // Returns outside FILL are stale (e.g. reads issued before a reset) and dropped.
  assign ret_fire = (state_q == ST_FILL) & bus.mem_rvalid;

  fill_counter u_req_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr),
    .inc_i  (req_fire),
    .cnt_o  (req_cnt),
    .wrap_o (req_wrap)
  );

  fill_counter u_ret_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr),
    .inc_i  (ret_fire),
    .cnt_o  (ret_cnt),
    .wrap_o (ret_wrap)
  );

  assign all_issued_d = cnt_clr ? 1'b0 : (all_issued_q | req_wrap);

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    base_d          = base_q;
    wr_addr_d       = wr_addr_q;
    wr_data_d       = wr_data_q;
    bus.mem_en      = 1'b0;
    bus.mem_wr      = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wdata   = '0;
    bus.d_wr_ack    = 1'b0;
    bus.fill_addr   = '0;
    bus.i_data_wr   = 1'b0;
    bus.d_data_wr   = 1'b0;
    bus.i_write_tag = 1'b0;
    bus.d_write_tag = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.d_wr_req) begin
          wr_addr_d = bus.d_wr_addr;
          wr_data_d = bus.d_wr_data;
          state_d   = ST_WRITE;
        end else if (bus.d_miss) begin
          owner_d = OWNER_D;
          base_d  = {bus.d_miss_addr[ADDR_WIDTH-1:BLOCK_OFFSET_BITS], {BLOCK_OFFSET_BITS{1'b0}}};
          state_d = ST_FILL;
        end else if (bus.i_miss) begin
          owner_d = OWNER_I;
          base_d  = {bus.i_miss_addr[ADDR_WIDTH-1:BLOCK_OFFSET_BITS], {BLOCK_OFFSET_BITS{1'b0}}};
          state_d = ST_FILL;
        end
      end

      ST_WRITE: begin
        bus.mem_en    = 1'b1;
        bus.mem_wr    = 1'b1;
        bus.mem_addr  = wr_addr_q;
        bus.mem_wdata = wr_data_q;
        bus.d_wr_ack  = 1'b1;
        state_d       = ST_IDLE;
      end

      ST_FILL: begin
        // The word offset occupies the cleared low bits of base, so OR cannot carry.
        if (req_fire) begin
          bus.mem_en   = 1'b1;
          bus.mem_addr = base_q | {{HI_BITS{1'b0}}, req_cnt, 1'b0};
        end
        if (ret_fire) begin
          bus.fill_addr = base_q | {{HI_BITS{1'b0}}, ret_cnt, 1'b0};
          bus.i_data_wr = (owner_q == OWNER_I);
          bus.d_data_wr = (owner_q == OWNER_D);
        end
        if (ret_wrap) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        bus.fill_addr   = base_q;
        bus.i_write_tag = (owner_q == OWNER_I);
        bus.d_write_tag = (owner_q == OWNER_D);
        state_d         = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      base_q       <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      all_issued_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      base_q       <= base_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      all_issued_q <= all_issued_d;
    end
  end

  assign bus.fill_data = bus.mem_rdata;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Bench for cache_fill_ctrl: a transaction-level model schedules the expected
// per-cycle memory requests, data-array writes and tag pulses for every accepted request.
module tb_cache_fill_ctrl;

  localparam int MEM_LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  cache_fill_ctrl_if #(.ADDR_WIDTH(16)) bus ();

  cache_fill_ctrl #(.ADDR_WIDTH(16), .MEM_LAT(MEM_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- counters / scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [31:0] exp_q[$];          // expected store transactions {addr, data}
  logic [15:0] rd_ev[int];        // cycle -> expected read address
  bit          wr_ev[int];        // cycle -> store write expected
  logic [16:0] fl_ev[int];        // cycle -> {owner, fill_addr} data-array write
  logic [16:0] tg_ev[int];        // cycle -> {owner, block base} tag pulse
  logic [15:0] mem_ret[int];      // memory model: cycle -> returned data
  int          busy_from = 0;
  int          free_at   = 0;

  bit drop_d_wr, drop_d_miss, drop_i_miss;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  // ---------------- reference model ----------------
  task automatic model_step();
    logic [15:0] base;
    logic        own;
    if (!rst || cyc < free_at) return;
    if (bus.d_wr_req) begin
      wr_ev[cyc+1] = 1'b1;
      exp_q.push_back({bus.d_wr_addr, bus.d_wr_data});
      busy_from = cyc + 1;
      free_at   = cyc + 2;
    end else if (bus.d_miss || bus.i_miss) begin
      own  = bus.d_miss;
      base = (bus.d_miss ? bus.d_miss_addr : bus.i_miss_addr) & 16'hFFF0;
      for (int k = 0; k < 8; k++) begin
        rd_ev[cyc+1+k]         = 16'(base + 2*k);
        fl_ev[cyc+1+MEM_LAT+k] = {own, 16'(base + 2*k)};
      end
      tg_ev[cyc+9+MEM_LAT] = {own, base};
      busy_from = cyc + 1;
      free_at   = cyc + 10 + MEM_LAT;
    end
  endtask

  task automatic model_reset();
    rd_ev.delete();
    wr_ev.delete();
    fl_ev.delete();
    tg_ev.delete();
    busy_from = cyc;
    free_at   = cyc;
  endtask

  task automatic check_cycle();
    logic       rd, wr, f, t, own_f, own_t, bsy;
    logic [7:0] ctl_got, ctl_exp;
    rd    = rd_ev.exists(cyc);
    wr    = wr_ev.exists(cyc);
    f     = fl_ev.exists(cyc);
    t     = tg_ev.exists(cyc);
    own_f = f ? fl_ev[cyc][16] : 1'b0;
    own_t = t ? tg_ev[cyc][16] : 1'b0;
    bsy   = (cyc >= busy_from) && (cyc < free_at);
    ctl_got = {bus.mem_en, bus.mem_wr, bus.d_wr_ack, bus.i_data_wr, bus.d_data_wr,
               bus.i_write_tag, bus.d_write_tag, bus.busy};
    ctl_exp = {rd | wr, wr, wr, f & ~own_f, f & own_f, t & ~own_t, t & own_t, bsy};
    check("ctl", 64'(ctl_got), 64'(ctl_exp));
    if (rd) check("rd_addr", 64'(bus.mem_addr), 64'(rd_ev[cyc]));
    if (bus.mem_en && bus.mem_wr) begin
      check("wr_q_nonempty", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) check("wr_txn", 64'({bus.mem_addr, bus.mem_wdata}), 64'(exp_q.pop_front()));
    end
    if (f) begin
      check("fill_addr", 64'(bus.fill_addr), 64'(fl_ev[cyc][15:0]));
      check("fill_data", 64'(bus.fill_data), 64'(mem_fn(fl_ev[cyc][15:0])));
    end
    if (t) check("tag_addr", 64'(bus.fill_addr), 64'(tg_ev[cyc][15:0]));
    if (!rst) check("rst_zero", {bus.mem_addr, bus.mem_wdata, bus.fill_addr, 8'h00, ctl_got}, 64'(0));
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    @(negedge clk);
    check_cycle();
    model_step();
    if (rst && bus.mem_en && !bus.mem_wr) mem_ret[cyc+MEM_LAT] = mem_fn(bus.mem_addr);
    drop_d_wr   = bus.d_wr_ack;
    drop_d_miss = bus.d_write_tag;
    drop_i_miss = bus.i_write_tag;
    @(posedge clk);
    #1;
    cyc++;
    if (mem_ret.exists(cyc)) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = mem_ret[cyc];
      mem_ret.delete(cyc);
    end else begin
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = 16'($urandom);
    end
    if (drop_d_wr)   bus.d_wr_req = 1'b0;
    if (drop_d_miss) bus.d_miss   = 1'b0;
    if (drop_i_miss) bus.i_miss   = 1'b0;
  endtask

  function automatic logic [15:0] rand_addr();
    return ($urandom_range(0, 3) == 0) ? (16'hFFF0 | 16'($urandom_range(0, 15))) : 16'($urandom);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    bus.i_miss = 0; bus.i_miss_addr = '0; bus.d_miss = 0; bus.d_miss_addr = '0;
    bus.d_wr_req = 0; bus.d_wr_addr = '0; bus.d_wr_data = '0;
    bus.mem_rdata = '0; bus.mem_rvalid = 0;

    repeat (3) tick();
    rst = 1'b1;

    // D miss at 0x1234
    bus.d_miss = 1; bus.d_miss_addr = 16'h1234;
    repeat (18) tick();

    // simultaneous I and D misses: D first, then I
    bus.d_miss = 1; bus.d_miss_addr = 16'h789A;
    bus.i_miss = 1; bus.i_miss_addr = 16'h0456;
    repeat (32) tick();

    // store wins over a pending D miss
    bus.d_wr_req = 1; bus.d_wr_addr = 16'h00A2; bus.d_wr_data = 16'hBEEF;
    bus.d_miss = 1; bus.d_miss_addr = 16'h2222;
    repeat (20) tick();

    // block at the top of the address space
    bus.i_miss = 1; bus.i_miss_addr = 16'hFFFE;
    repeat (16) tick();

    // reset in cycle 6 of a fill, stale returns afterwards, then a fresh miss
    bus.d_miss = 1; bus.d_miss_addr = 16'h4444;
    repeat (6) tick();
    rst = 1'b0;
    bus.d_miss = 0;
    model_reset();
    #1;
    check("rst_async", {bus.mem_en, bus.i_data_wr, bus.d_data_wr, bus.d_write_tag, bus.busy}, 64'(0));
    repeat (2) tick();
    rst = 1'b1;
    repeat (8) tick();
    bus.i_miss = 1; bus.i_miss_addr = 16'h0808;
    repeat (16) tick();

    // I miss withdrawn mid-fill still completes
    bus.i_miss = 1; bus.i_miss_addr = 16'h3006;
    repeat (6) tick();
    bus.i_miss = 0;
    repeat (12) tick();

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      if (!bus.d_wr_req && $urandom_range(0, 15) == 0) begin
        bus.d_wr_req  = 1;
        bus.d_wr_addr = rand_addr();
        bus.d_wr_data = 16'($urandom);
      end
      if (!bus.d_miss && $urandom_range(0, 19) == 0) begin
        bus.d_miss = 1; bus.d_miss_addr = rand_addr();
      end
      if (!bus.i_miss && $urandom_range(0, 9) == 0) begin
        bus.i_miss = 1; bus.i_miss_addr = rand_addr();
      end else if (bus.i_miss && $urandom_range(0, 63) == 0) begin
        bus.i_miss = 0;
      end
      tick();
    end

    // drain
    bus.i_miss = 0; bus.d_miss = 0;
    repeat (30) begin
      if (bus.d_wr_ack) bus.d_wr_req = 0;
      tick();
    end
    bus.d_wr_req = 0;
    repeat (4) tick();
    check("store_q_empty", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cache_fill_ctrl.md
# cache_fill_ctrl

Miss-handling and memory-arbitration controller between the two `cache` instances (I-cache, D-cache) and the single multi-cycle unified memory. Arbitrates D-cache write-through stores, D-cache misses and I-cache misses. Services a miss by streaming the 8 words of the 16-byte block from memory into the missing cache's data array, then pulsing that cache's `write_tag_array`. Sits beside the two caches in the memory subsystem; the pipeline stalls on each cache's `miss_detected`.

## Interface
Parameters:
- `ADDR_WIDTH`, 16, byte address width.
- `MEM_LAT`, 4, cycles from a read request (`mem_en & ~mem_wr`) to its `mem_rvalid`; memory is pipelined, one request per cycle.

Ports:
- `clk` in 1 — single clock; all state on rising edge.
- `rst` in 1 — asynchronous, active-low reset.
- `i_miss` in 1 — I-cache `miss_detected`.
- `i_miss_addr` in ADDR_WIDTH — I-cache miss address.
- `d_miss` in 1 — D-cache `miss_detected`.
- `d_miss_addr` in ADDR_WIDTH — D-cache miss address.
- `d_wr_req` in 1 — D-cache write-through store request; held until `d_wr_ack`.
- `d_wr_addr` in ADDR_WIDTH, `d_wr_data` in 16 — store address and data.
- `d_wr_ack` out 1 — one-cycle pulse, store issued to memory.
- `mem_en` out 1, `mem_wr` out 1, `mem_addr` out ADDR_WIDTH, `mem_wdata` out 16 — memory request.
- `mem_rdata` in 16, `mem_rvalid` in 1 — memory read return.
- `fill_addr` out ADDR_WIDTH — address presented to the filling cache (block base + word offset).
- `fill_data` out 16 — equals `mem_rdata`.
- `i_data_wr`, `d_data_wr` out 1 — data-array write strobe to the I- or D-cache.
- `i_write_tag`, `d_write_tag` out 1 — one-cycle `write_tag_array` pulse.
- `busy` out 1 — high in any state other than IDLE.

## Operation
- States: IDLE, WRITE, FILL, DONE. Registers: `owner` (0=I, 1=D), `base` (miss address with bits [3:0] cleared), `req_cnt` (3-bit, plus issued-all flag), `ret_cnt` (3-bit).
- IDLE, fixed priority: `d_wr_req` → WRITE; else `d_miss` → FILL with owner=D; else `i_miss` → FILL with owner=I. `base` and `owner` latch on the transition cycle. Counters clear.
- WRITE (1 cycle): `mem_en=1`, `mem_wr=1`, `mem_addr=d_wr_addr`, `mem_wdata=d_wr_data`, `d_wr_ack=1`; → IDLE.
- FILL: while not all issued, `mem_en=1`, `mem_wr=0`, `mem_addr=base+2*req_cnt`, and `req_cnt` increments. On each `mem_rvalid`: selected `*_data_wr=1`, `fill_addr=base+2*ret_cnt`, `ret_cnt` increments. `mem_rvalid` with `ret_cnt==7` → DONE.
- DONE (1 cycle): selected `*_write_tag=1`, `fill_addr=base`; → IDLE.
- Address arithmetic is modulo 2^ADDR_WIDTH. Word offset is 0..14 in steps of 2 and never carries out of the block.
- `mem_rvalid` outside FILL is ignored, covering stale returns after a reset.
- Miss deasserting during FILL does not abort; the full block is written and tagged.
- Simultaneous `i_miss` and `d_miss`: the D-cache fill runs first; the I-cache fill starts from IDLE after DONE if `i_miss` is still high.
- Requests arriving while `busy` wait; no queueing beyond the held request lines.
- Unselected cache strobes are 0 in every state.

## Timing
- Reset (`rst=0`, async): state=IDLE; all outputs 0; counters and `owner` 0; `base` 0.
- Fill accepted at edge T (IDLE→FILL): reads issue in cycles T+1..T+8; data writes occur in cycles T+1+MEM_LAT..T+8+MEM_LAT; `*_write_tag` at T+9+MEM_LAT; IDLE at T+10+MEM_LAT. With MEM_LAT=4 this is 14 cycles from acceptance to IDLE.
- Store: accepted at T, memory write and `d_wr_ack` in T+1, IDLE at T+2.
- All outputs are decoded from registered state/counters and registered inputs (`mem_rdata` passes combinationally to `fill_data`).

## Structure
- Shared package `mem_ctrl_pkg`: state encoding, `WORDS_PER_BLOCK=8`, `BLOCK_OFFSET_BITS=4`, owner encodings.
- One sub-module, `fill_counter`: 3-bit counter with clear, increment and wrap flag, instantiated twice (issue and return).

## Test plan
- D-miss at 0x1234, MEM_LAT=4 → reads 0x1230..0x123E in cycles 1–8; 8 `d_data_wr` with `fill_addr` 0x1230..0x123E in cycles 5–12; `d_write_tag` in cycle 13; `i_*` strobes stay 0.
- `i_miss` and `d_miss` both high in the same cycle → full D fill (base of `d_miss_addr`), then I fill starts the cycle after IDLE.
- `d_wr_req` with `d_miss` high, addr 0x00A2 data 0xBEEF → one memory write of 0xBEEF to 0x00A2 plus `d_wr_ack`, then the D fill begins.
- Miss at 0xFFFE → reads 0xFFF0..0xFFFE, no wrap into 0x0000.
- `rst` low during cycle 6 of a fill → outputs 0 immediately; after release, in-flight `mem_rvalid` produces no `*_data_wr`; a new miss is serviced normally.
- `i_miss` dropped mid-fill → remaining words still written, then `i_write_tag` pulses.
